// File: rtl/mac_pkg.sv
// ============================================================================
// Module   : mac_pkg
// Summary  : Shared state encoding and default timing constants for the
//            mac_burst_ctrl memory access controller.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mac_pkg;

    localparam logic [2:0] C_ST_IDLE     = 3'b000;
    localparam logic [2:0] C_ST_WAIT_ACK = 3'b001;
    localparam logic [2:0] C_ST_GAP      = 3'b010;
    localparam logic [2:0] C_ST_NEXT     = 3'b011;
    localparam logic [2:0] C_ST_ERR      = 3'b100;

    localparam int C_DEF_ADDR_STEP = 4;
    localparam int C_DEF_TO_CYC    = 15;

    // A request is only meaningful when it names exactly one direction.
    function automatic logic mac_req_valid(input logic req, input logic mr, input logic mw);
        return req & (mr ^ mw);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mac_wait_timer.sv
// ============================================================================
// Module   : mac_wait_timer
// Summary  : Clearable wait-state counter; o_expired flags the enabled cycle
//            on which the count reaches LIMIT.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mac_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign o_expired = i_en && (cnt_q == CW'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en && !o_expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mac_burst_ctrl.sv
// ============================================================================
// Module   : mac_burst_ctrl
// Summary  : DLX memory bus access controller with multi-beat bursts.
//            Optional wait-state abort compiled in with MAC_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mac_burst_ctrl
    import mac_pkg::*;
#(
    parameter int AW        = 32,
    parameter int BL_W      = 3,
    parameter int ADDR_STEP = C_DEF_ADDR_STEP,
    parameter int TO_CYC    = C_DEF_TO_CYC
) (
    input  logic            clk,
    input  logic            reset_N,
    input  logic            REQ,
    input  logic            MR,
    input  logic            MW,
    input  logic [BL_W-1:0] BURST_LEN,
    input  logic [AW-1:0]   ADDR_IN,
    input  logic            ACK_N,
    output logic [AW-1:0]   ADDR_OUT,
    output logic            AS_N,
    output logic            WR_N,
    output logic            busy,
    output logic            stop_n_1,
    output logic [BL_W-1:0] BEAT,
    output logic            DONE,
    output logic            TIMEOUT,
    output logic [2:0]      STATE
);

    logic [2:0]      state_q;
    logic [2:0]      state_d;
    logic [AW-1:0]   addr_q;
    logic [AW-1:0]   addr_d;
    logic [BL_W-1:0] beat_q;
    logic [BL_W-1:0] beat_d;
    logic [BL_W-1:0] len_q;
    logic [BL_W-1:0] len_d;
    logic            wr_q;
    logic            wr_d;

    logic            w_accept;
    logic            w_ack;
    logic            w_last;
    logic            w_timeout;

    assign w_accept = mac_req_valid(REQ, MR, MW);
    assign w_ack    = !ACK_N;
    assign w_last   = (beat_q == len_q);

`ifdef MAC_TIMEOUT_EN
    logic w_wait_clr;
    logic w_wait_en;
    logic w_wait_expired;

    // Any non-WAIT_ACK cycle resets the count, so each beat gets a full budget.
    assign w_wait_clr = (state_q != C_ST_WAIT_ACK);
    assign w_wait_en  = (state_q == C_ST_WAIT_ACK) && ACK_N;

    mac_wait_timer #(
        .LIMIT (TO_CYC)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (reset_N),
        .i_clr     (w_wait_clr),
        .i_en      (w_wait_en),
        .o_expired (w_wait_expired)
    );

    assign w_timeout = w_wait_expired;
    assign TIMEOUT   = (state_q == C_ST_ERR);
`else
    logic unused_to_cyc;

    assign unused_to_cyc = (TO_CYC != 0);
    assign w_timeout     = 1'b0;
    assign TIMEOUT       = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q <= C_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_IDLE: begin
                if (w_accept) begin
                    state_d = C_ST_WAIT_ACK;
                end
            end
            C_ST_WAIT_ACK: begin
                // An acknowledge on the limit edge takes priority over the abort.
                if (w_ack) begin
                    state_d = w_last ? C_ST_NEXT : C_ST_GAP;
                end else if (w_timeout) begin
                    state_d = C_ST_ERR;
                end
            end
            C_ST_GAP:  state_d = C_ST_WAIT_ACK;
            C_ST_NEXT: state_d = C_ST_IDLE;
            C_ST_ERR:  state_d = C_ST_IDLE;
            default:   state_d = C_ST_IDLE;
        endcase
    end

    always_comb begin
        AS_N     = 1'b1;
        WR_N     = 1'b1;
        stop_n_1 = 1'b1;
        DONE     = 1'b0;
        case (state_q)
            C_ST_WAIT_ACK: begin
                AS_N     = 1'b0;
                WR_N     = !wr_q;
                stop_n_1 = 1'b0;
            end
            C_ST_GAP: begin
                stop_n_1 = 1'b0;
            end
            C_ST_NEXT, C_ST_ERR: begin
                DONE = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        beat_d = beat_q;
        len_d  = len_q;
        wr_d   = wr_q;
        if ((state_q == C_ST_IDLE) && w_accept) begin
            addr_d = ADDR_IN;
            wr_d   = MW;
            len_d  = BURST_LEN;
            beat_d = '0;
        end else if ((state_q == C_ST_WAIT_ACK) && w_ack && !w_last) begin
            beat_d = beat_q + 1'b1;
            addr_d = addr_q + AW'(ADDR_STEP);
        end
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            addr_q <= '0;
            beat_q <= '0;
            len_q  <= '0;
            wr_q   <= 1'b0;
        end else begin
            addr_q <= addr_d;
            beat_q <= beat_d;
            len_q  <= len_d;
            wr_q   <= wr_d;
        end
    end

    assign busy     = REQ || (state_q != C_ST_IDLE);
    assign ADDR_OUT = addr_q;
    assign BEAT     = beat_q;
    assign STATE    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_burst_ctrl.sv
// ============================================================================
// Module   : tb_mac_burst_ctrl
// Summary  : Scoreboard bench for mac_burst_ctrl; timeout cases follow
//            MAC_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mac_burst_ctrl;

    localparam int AW   = 32;
    localparam int BL_W = 3;

    logic            clk       = 1'b0;
    logic            reset_N   = 1'b0;
    logic            REQ       = 1'b0;
    logic            MR        = 1'b0;
    logic            MW        = 1'b0;
    logic [BL_W-1:0] BURST_LEN = '0;
    logic [AW-1:0]   ADDR_IN   = '0;
    logic            ACK_N     = 1'b1;
    logic [AW-1:0]   ADDR_OUT;
    logic            AS_N;
    logic            WR_N;
    logic            busy;
    logic            stop_n_1;
    logic [BL_W-1:0] BEAT;
    logic            DONE;
    logic            TIMEOUT;
    logic [2:0]      STATE;

    always #5 clk = ~clk;

    mac_burst_ctrl #(
        .AW        (AW),
        .BL_W      (BL_W),
        .ADDR_STEP (4),
        .TO_CYC    (15)
    ) dut (
        .clk       (clk),
        .reset_N   (reset_N),
        .REQ       (REQ),
        .MR        (MR),
        .MW        (MW),
        .BURST_LEN (BURST_LEN),
        .ADDR_IN   (ADDR_IN),
        .ACK_N     (ACK_N),
        .ADDR_OUT  (ADDR_OUT),
        .AS_N      (AS_N),
        .WR_N      (WR_N),
        .busy      (busy),
        .stop_n_1  (stop_n_1),
        .BEAT      (BEAT),
        .DONE      (DONE),
        .TIMEOUT   (TIMEOUT),
        .STATE     (STATE)
    );

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic            wr_n;
        logic [BL_W-1:0] beat;
    } beat_t;

    beat_t exp_q[$];
    beat_t obs_q[$];

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int as_low_cnt   = 0;
    int done_cnt     = 0;
    int to_cnt       = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!AS_N)   as_low_cnt <= as_low_cnt + 1;
        if (DONE)    done_cnt   <= done_cnt + 1;
        if (TIMEOUT) to_cnt     <= to_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst(input logic [AW-1:0] addr, input logic wr, input int len);
        for (int b = 0; b <= len; b++) begin
            exp_q.push_back('{addr: addr + AW'(4 * b), wr_n: !wr, beat: BL_W'(b)});
        end
    endtask

    task automatic start_req(input logic [AW-1:0] addr, input logic mr, input logic mw, input int len);
        ADDR_IN   = addr;
        MR        = mr;
        MW        = mw;
        BURST_LEN = BL_W'(len);
        REQ       = 1'b1;
        tick();
        REQ       = 1'b0;
    endtask

    // Slave model: per beat waits for the strobe, stalls w cycles, then acknowledges.
    task automatic serve_beats(input int n, input int w, output bit ok);
        ok = 1'b1;
        for (int b = 0; b < n; b++) begin
            int guard;
            guard = 0;
            while (AS_N !== 1'b0 && guard < 50) begin
                tick();
                guard++;
            end
            if (AS_N !== 1'b0) begin
                ok = 1'b0;
                return;
            end
            for (int i = 0; i < w; i++) tick();
            obs_q.push_back('{addr: ADDR_OUT, wr_n: WR_N, beat: BEAT});
            ACK_N = 1'b0;
            tick();
            ACK_N = 1'b1;
        end
    endtask

    task automatic test_reset();
        #12;
        tests_run++;
        if (AS_N !== 1'b1 || WR_N !== 1'b1 || stop_n_1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_strobes: got as_n=%b wr_n=%b stop_n_1=%b, expected 1 1 1", AS_N, WR_N, stop_n_1);
        end
        tests_run++;
        if (DONE !== 1'b0 || TIMEOUT !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got done=%b timeout=%b busy=%b, expected 0 0 0", DONE, TIMEOUT, busy);
        end
        tests_run++;
        if (STATE !== 3'b000 || BEAT !== '0 || ADDR_OUT !== '0) begin
            tests_failed++;
            $display("FAIL reset_regs: got state=%b beat=%0d addr=%h, expected 000 0 0", STATE, BEAT, ADDR_OUT);
        end
        @(negedge clk);
        reset_N = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        int  c0, d0, a0;
        bit  ok;
        beat_t e, o;
        push_burst(32'h100, 1'b0, 0);
        d0 = done_cnt;
        a0 = as_low_cnt;
        start_req(32'h100, 1'b1, 1'b0, 0);
        c0 = cyc;
        tests_run++;
        if (STATE !== 3'b001 || AS_N !== 1'b0 || WR_N !== 1'b1 || stop_n_1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_wait: got state=%b as_n=%b wr_n=%b stop=%b, expected 001 0 1 0", STATE, AS_N, WR_N, stop_n_1);
        end
        serve_beats(1, 2, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL rd_strobe: got no AS_N low, expected AS_N low within bound");
        end
        tests_run++;
        if (STATE !== 3'b011 || DONE !== 1'b1 || ADDR_OUT !== 32'h100 || stop_n_1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL rd_next: got state=%b done=%b addr=%h stop=%b, expected 011 1 00000100 1", STATE, DONE, ADDR_OUT, stop_n_1);
        end
        tick();
        tests_run++;
        if (STATE !== 3'b000 || DONE !== 1'b0 || cyc - c0 !== 4) begin
            tests_failed++;
            $display("FAIL rd_idle: got state=%b done=%b cycles=%0d, expected 000 0 4", STATE, DONE, cyc - c0);
        end
        tests_run++;
        if (done_cnt - d0 !== 1 || as_low_cnt - a0 !== 3) begin
            tests_failed++;
            $display("FAIL rd_pulses: got done=%0d as_low=%0d, expected 1 3", done_cnt - d0, as_low_cnt - a0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("FAIL rd_beat: got no beat, expected addr=%h", e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    tests_failed++;
                    $display("FAIL rd_beat: got addr=%h wr_n=%b beat=%0d, expected addr=%h wr_n=%b beat=%0d", o.addr, o.wr_n, o.beat, e.addr, e.wr_n, e.beat);
                end
            end
        end
    endtask

    task automatic test_write_burst();
        int  c0, d0, a0;
        bit  ok;
        beat_t e, o;
        push_burst(32'hFFFF_FFF8, 1'b1, 3);
        d0 = done_cnt;
        a0 = as_low_cnt;
        start_req(32'hFFFF_FFF8, 1'b0, 1'b1, 3);
        c0 = cyc;
        serve_beats(4, 0, ok);
        tests_run++;
        if (!ok || STATE !== 3'b011 || cyc - c0 !== 7) begin
            tests_failed++;
            $display("FAIL wr_burst_timing: got ok=%b state=%b cycles=%0d, expected 1 011 7", ok, STATE, cyc - c0);
        end
        tests_run++;
        if (ADDR_OUT !== 32'h0000_0004 || BEAT !== 3'd3) begin
            tests_failed++;
            $display("FAIL wr_burst_wrap: got addr=%h beat=%0d, expected 00000004 3", ADDR_OUT, BEAT);
        end
        tick();
        tests_run++;
        if (as_low_cnt - a0 !== 4 || done_cnt - d0 !== 1 || STATE !== 3'b000) begin
            tests_failed++;
            $display("FAIL wr_burst_pulses: got as_low=%0d done=%0d state=%b, expected 4 1 000", as_low_cnt - a0, done_cnt - d0, STATE);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("FAIL wr_beat: got no beat, expected addr=%h", e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    tests_failed++;
                    $display("FAIL wr_beat: got addr=%h wr_n=%b beat=%0d, expected addr=%h wr_n=%b beat=%0d", o.addr, o.wr_n, o.beat, e.addr, e.wr_n, e.beat);
                end
            end
        end
    endtask

    task automatic test_illegal_req();
        ADDR_IN = 32'h700;
        MR      = 1'b1;
        MW      = 1'b1;
        REQ     = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL illegal_busy: got %b, expected 1", busy);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (STATE !== 3'b000 || AS_N !== 1'b1) begin
                tests_failed++;
                $display("FAIL illegal_both: got state=%b as_n=%b, expected 000 1", STATE, AS_N);
            end
        end
        MR    = 1'b0;
        MW    = 1'b0;
        ACK_N = 1'b0;
        tick();
        tick();
        tests_run++;
        if (STATE !== 3'b000 || AS_N !== 1'b1 || DONE !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal_none: got state=%b as_n=%b done=%b, expected 000 1 0", STATE, AS_N, DONE);
        end
        REQ   = 1'b0;
        ACK_N = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal_busy_rel: got %b, expected 0", busy);
        end
        tick();
    endtask

    task automatic test_timeout();
        int  c0, t0, guard;
        bit  ok;
        beat_t e, o;
        t0 = to_cnt;
`ifdef MAC_TIMEOUT_EN
        start_req(32'h400, 1'b1, 1'b0, 1);
        c0    = cyc;
        guard = 0;
        while (STATE !== 3'b100 && guard < 40) begin
            tick();
            guard++;
        end
        tests_run++;
        if (STATE !== 3'b100 || cyc - c0 !== 15) begin
            tests_failed++;
            $display("FAIL to_err_entry: got state=%b cycles=%0d, expected 100 15", STATE, cyc - c0);
        end
        tests_run++;
        if (TIMEOUT !== 1'b1 || DONE !== 1'b1 || stop_n_1 !== 1'b1 || AS_N !== 1'b1) begin
            tests_failed++;
            $display("FAIL to_err_out: got to=%b done=%b stop=%b as_n=%b, expected 1 1 1 1", TIMEOUT, DONE, stop_n_1, AS_N);
        end
        tick();
        tests_run++;
        if (STATE !== 3'b000 || TIMEOUT !== 1'b0 || to_cnt - t0 !== 1) begin
            tests_failed++;
            $display("FAIL to_err_exit: got state=%b to=%b pulses=%0d, expected 000 0 1", STATE, TIMEOUT, to_cnt - t0);
        end
        push_burst(32'h480, 1'b0, 0);
        start_req(32'h480, 1'b1, 1'b0, 0);
        serve_beats(1, 14, ok);
        tests_run++;
        if (!ok || STATE !== 3'b011 || TIMEOUT !== 1'b0) begin
            tests_failed++;
            $display("FAIL to_limit_ack: got ok=%b state=%b to=%b, expected 1 011 0", ok, STATE, TIMEOUT);
        end
        tick();
        tests_run++;
        if (to_cnt - t0 !== 1) begin
            tests_failed++;
            $display("FAIL to_limit_pulses: got %0d, expected 1", to_cnt - t0);
        end
`else
        push_burst(32'h480, 1'b0, 0);
        start_req(32'h480, 1'b1, 1'b0, 0);
        c0 = cyc;
        for (int i = 0; i < 30; i++) tick();
        tests_run++;
        if (STATE !== 3'b001 || AS_N !== 1'b0 || cyc - c0 !== 30) begin
            tests_failed++;
            $display("FAIL to_wait_forever: got state=%b as_n=%b, expected 001 0", STATE, AS_N);
        end
        serve_beats(1, 0, ok);
        tests_run++;
        if (!ok || STATE !== 3'b011 || TIMEOUT !== 1'b0) begin
            tests_failed++;
            $display("FAIL to_late_ack: got ok=%b state=%b to=%b, expected 1 011 0", ok, STATE, TIMEOUT);
        end
        tick();
        tests_run++;
        if (to_cnt - t0 !== 0) begin
            tests_failed++;
            $display("FAIL to_no_pulse: got %0d, expected 0", to_cnt - t0);
        end
`endif
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("FAIL to_beat: got no beat, expected addr=%h", e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    tests_failed++;
                    $display("FAIL to_beat: got addr=%h wr_n=%b beat=%0d, expected addr=%h wr_n=%b beat=%0d", o.addr, o.wr_n, o.beat, e.addr, e.wr_n, e.beat);
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int  d0;
        bit  ok;
        beat_t e, o;
        push_burst(32'h200, 1'b0, 3);
        start_req(32'h200, 1'b1, 1'b0, 3);
        serve_beats(2, 0, ok);
        tick();
        tests_run++;
        if (!ok || BEAT !== 3'd2 || AS_N !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_pre: got ok=%b beat=%0d as_n=%b, expected 1 2 0", ok, BEAT, AS_N);
        end
        d0 = done_cnt;
        #2;
        reset_N = 1'b0;
        #1;
        tests_run++;
        if (AS_N !== 1'b1 || STATE !== 3'b000 || BEAT !== '0 || stop_n_1 !== 1'b1 || ADDR_OUT !== '0) begin
            tests_failed++;
            $display("FAIL rst_async: got as_n=%b state=%b beat=%0d stop=%b addr=%h, expected 1 000 0 1 0", AS_N, STATE, BEAT, stop_n_1, ADDR_OUT);
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL rst_beat: got addr=%h wr_n=%b beat=%0d, expected addr=%h wr_n=%b beat=%0d", o.addr, o.wr_n, o.beat, e.addr, e.wr_n, e.beat);
            end
        end
        tests_run++;
        if (exp_q.size() !== 2) begin
            tests_failed++;
            $display("FAIL rst_abandoned: got %0d pending beats, expected 2", exp_q.size());
        end
        exp_q.delete();
        @(negedge clk);
        reset_N = 1'b1;
        tick();
        tests_run++;
        if (done_cnt - d0 !== 0 || STATE !== 3'b000) begin
            tests_failed++;
            $display("FAIL rst_no_done: got done=%0d state=%b, expected 0 000", done_cnt - d0, STATE);
        end
        push_burst(32'h300, 1'b1, 0);
        start_req(32'h300, 1'b0, 1'b1, 0);
        tests_run++;
        if (BEAT !== '0 || ADDR_OUT !== 32'h300 || WR_N !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_restart: got beat=%0d addr=%h wr_n=%b, expected 0 00000300 0", BEAT, ADDR_OUT, WR_N);
        end
        serve_beats(1, 0, ok);
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("FAIL rst_new_beat: got no beat, expected addr=%h", e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    tests_failed++;
                    $display("FAIL rst_new_beat: got addr=%h wr_n=%b beat=%0d, expected addr=%h wr_n=%b beat=%0d", o.addr, o.wr_n, o.beat, e.addr, e.wr_n, e.beat);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        beat_t e, o;
        push_burst(32'h500, 1'b0, 0);
        ADDR_IN   = 32'h500;
        MR        = 1'b1;
        MW        = 1'b0;
        BURST_LEN = '0;
        REQ       = 1'b1;
        tick();
        serve_beats(1, 0, ok);
        ADDR_IN = 32'h600;
        push_burst(32'h600, 1'b0, 0);
        tests_run++;
        if (!ok || STATE !== 3'b011) begin
            tests_failed++;
            $display("FAIL b2b_first: got ok=%b state=%b, expected 1 011", ok, STATE);
        end
        tick();
        tests_run++;
        if (STATE !== 3'b000 || AS_N !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_idle_gap: got state=%b as_n=%b busy=%b, expected 000 1 1", STATE, AS_N, busy);
        end
        tick();
        REQ = 1'b0;
        tests_run++;
        if (STATE !== 3'b001 || ADDR_OUT !== 32'h600) begin
            tests_failed++;
            $display("FAIL b2b_reaccept: got state=%b addr=%h, expected 001 00000600", STATE, ADDR_OUT);
        end
        serve_beats(1, 0, ok);
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("FAIL b2b_beat: got no beat, expected addr=%h", e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    tests_failed++;
                    $display("FAIL b2b_beat: got addr=%h wr_n=%b beat=%0d, expected addr=%h wr_n=%b beat=%0d", o.addr, o.wr_n, o.beat, e.addr, e.wr_n, e.beat);
                end
            end
        end
        tests_run++;
        if (obs_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL extra_beats: got %0d unexpected beats, expected 0", obs_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_burst();
        test_illegal_req();
        test_timeout();
        test_reset_mid_burst();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200us, expected bench to finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
